// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and the instruction decoder:
// word widths, reset PC, sequential step and the fetch FSM state type.
package cpu_pkg;

    // Instruction/data word width; the decoder's WIDTH must match this.
    localparam int WIDTH = 32;

    // PC and memory address width.
    localparam int ADDR_W = 32;

    // Default PC loaded on reset.
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Default byte increment between sequential fetches.
    localparam int PC_STEP_DEF = 4;

    // Fetch FSM states.
    //   IDLE  : waiting for fetch_en, no memory traffic
    //   FETCH : request outstanding for the current (right-path) address
    //   HOLD  : output slot full, waiting for the decoder or a redirect
    //   FLUSH : wrong-path request still outstanding, its data is dropped
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    // True in the states that keep a memory request on the bus.
    function automatic logic state_has_req(input fetch_state_t s);
        return (s == FETCH) || (s == FLUSH);
    endfunction

    // True in the only state where the output slot holds an instruction.
    function automatic logic state_has_slot(input fetch_state_t s);
        return (s == HOLD);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, runs a single-outstanding req/ack handshake to
// instruction memory, parks each fetched word in a one-entry output slot
// and hands it to the decoder, and follows branch/jump redirects while
// discarding any fetch that turns out to be on the wrong path.
//
// Handshakes:
//   imem side : imem_req rises and stays high (with imem_addr frozen) until
//               the cycle imem_ack is sampled high; imem_rdata is valid only
//               in that cycle. The ack may land in the first request cycle.
//   decoder   : a transfer happens on a clock edge where if_valid and
//               if_ready are both high and no redirect is present; while
//               if_valid is high and if_ready low, if_instr/if_pc hold.
// All outputs come straight from flops, so if_ready has no combinational
// path to imem_req.
module instr_fetch #(
    parameter int                        WIDTH    = cpu_pkg::WIDTH,
    parameter int                        ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]         RESET_PC = ADDR_W'(cpu_pkg::RESET_PC_DEF),
    parameter int                        PC_STEP  = cpu_pkg::PC_STEP_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  fetch_en,

    output logic                  imem_req,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic                  imem_ack,
    input  logic [WIDTH-1:0]      imem_rdata,

    input  logic                  redir_valid,
    input  logic [ADDR_W-1:0]     redir_pc,

    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [WIDTH-1:0]      if_instr,
    output logic [ADDR_W-1:0]     if_pc,

    output cpu_pkg::fetch_state_t dbg_state
);

    import cpu_pkg::*;

    // Sequential increment as an address-wide constant; the add wraps
    // modulo 2^ADDR_W so the top word rolls over to address 0.
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_t      state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_q,      req_d;
    logic              valid_q,    valid_d;
    logic [WIDTH-1:0]  instr_q,    instr_d;
    logic [ADDR_W-1:0] slot_pc_q,  slot_pc_d;

    // Next-state, PC, request address and slot contents.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        slot_pc_d  = slot_pc_q;

        case (state_q)
            IDLE: begin
                // A redirect while idle just retargets where fetching
                // will start; a simultaneous fetch_en uses that target.
                if (redir_valid) begin
                    pc_d = redir_pc;
                end
                if (fetch_en) begin
                    state_d    = FETCH;
                    req_addr_d = pc_d;
                end
            end

            FETCH: begin
                if (redir_valid) begin
                    pc_d = redir_pc;
                    if (imem_ack) begin
                        // Wrong-path word is back already: drop it and
                        // issue the target at once.
                        req_addr_d = redir_pc;
                    end else begin
                        // Request still in flight: its address must stay
                        // put, so let it drain in FLUSH.
                        state_d = FLUSH;
                    end
                end else if (imem_ack) begin
                    instr_d   = imem_rdata;
                    slot_pc_d = req_addr_q;
                    pc_d      = req_addr_q + STEP;
                    state_d   = HOLD;
                end
            end

            HOLD: begin
                if (redir_valid) begin
                    // Squash the slot even if the decoder is ready now.
                    pc_d       = redir_pc;
                    req_addr_d = redir_pc;
                    state_d    = FETCH;
                end else if (if_ready) begin
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end

            FLUSH: begin
                // Latest redirect wins; the outstanding request keeps its
                // old address and its data is never written to the slot.
                if (redir_valid) begin
                    pc_d = redir_pc;
                end
                if (imem_ack) begin
                    req_addr_d = pc_d;
                    state_d    = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are decoded from the state being entered.
        req_d   = state_has_req(state_d);
        valid_d = state_has_slot(state_d);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            slot_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            slot_pc_q  <= slot_pc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = req_addr_q;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = slot_pc_q;
    assign dbg_state = state_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder (`controller`).
- Maintains the PC and runs a single-outstanding request/ack handshake to instruction memory.
- Holds each fetched word in a one-entry output slot; the slot's `if_instr` drives the decoder's `in32` under a valid/ready handshake.
- Accepts branch/jump redirects from later stages and discards wrong-path fetches.

Parameters:
- WIDTH, 32, instruction and data word width; must equal the decoder's WIDTH.
- ADDR_W, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- fetch_en  input  1  start fetching; sampled only in IDLE.
- imem_req  output  1  memory request; held high until imem_ack.
- imem_addr  output  ADDR_W  request address; stable while imem_req is high.
- imem_ack  input  1  one-cycle pulse; imem_rdata is valid in that cycle; may arrive in the same cycle as imem_req.
- imem_rdata  input  WIDTH  returned instruction word.
- redir_valid  input  1  redirect request (taken branch or jump).
- redir_pc  input  ADDR_W  redirect target.
- if_valid  output  1  output slot holds a valid instruction.
- if_ready  input  1  decoder accepts the slot.
- if_instr  output  WIDTH  instruction word, feeds the decoder's `in32`.
- if_pc  output  ADDR_W  address of if_instr.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC.
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0.
  - Reset mid-request abandons it; any later stray imem_ack is ignored because the block is in IDLE.
- States: IDLE, FETCH, HOLD, FLUSH. Outputs are registered or decoded from state; there is no combinational path from if_ready to imem_req.
- imem_req=1 only in FETCH and FLUSH. imem_addr=req_addr, which is latched from pc on entry to FETCH.
- IDLE:
  - fetch_en=1 -> FETCH with req_addr=pc.
  - redir_valid in IDLE loads pc=redir_pc.
- FETCH, redirect priority:
  - redir_valid & imem_ack -> discard rdata; pc=req_addr=redir_pc; stay in FETCH.
  - redir_valid & !imem_ack -> FLUSH; pc=redir_pc; req_addr unchanged (address must stay stable).
- FETCH, no redirect:
  - imem_ack -> if_instr=imem_rdata, if_pc=req_addr, if_valid=1; pc=req_addr+PC_STEP; go to HOLD.
  - no ack -> hold imem_req and imem_addr unchanged.
- HOLD:
  - redir_valid -> if_valid=0 (instruction squashed even if if_ready=1 this cycle); pc=redir_pc; FETCH with req_addr=redir_pc.
  - else if_ready=1 -> transfer completes; if_valid=0; FETCH with req_addr=pc.
  - else hold the slot unchanged; no memory request.
- FLUSH:
  - Keep the wrong-path request at the old req_addr until imem_ack.
  - Discard the returned data; never update the slot.
  - On ack -> FETCH with req_addr=pc.
  - A further redir_valid in FLUSH overwrites pc (last redirect wins).
  - redir_valid & imem_ack in the same cycle -> FETCH with req_addr=redir_pc.
- Invariants:
  - if_valid=1 only in HOLD.
  - At most one outstanding memory request.
  - if_instr and if_pc do not change while if_valid=1 and if_ready=0.
- Throughput: one instruction per 2 cycles with a zero-wait memory (ack in the same cycle as req); N-cycle memory latency adds N cycles.
- Arithmetic: pc increment is modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- redir_pc is used as given; no alignment check.

Decomposition:
- Shared package `cpu_pkg`:
  - WIDTH and ADDR_W constants, also used by the decoder.
  - `fetch_state_t` enum {IDLE, FETCH, HOLD, FLUSH}.
  - RESET_PC default.
- Single module; no sub-module is warranted. PC register, req_addr register, output slot and FSM all sit inline.

Test Plan:
- Reset then fetch_en=1, memory acks in the same cycle as req with words 0x8123_4567, 0x0000_0001, if_ready=1 -> if_valid/if_pc sequence 0x0,0x4 on every second cycle; if_instr matches each word.
- Memory with 3-cycle ack latency -> imem_addr stays 0x4 across all wait cycles; if_valid rises the cycle after the ack.
- Slot full, if_ready=0 for 5 cycles -> if_instr/if_pc stable; imem_req=0 throughout; next fetch at pc+4 after if_ready=1.
- redir_valid with redir_pc=0x100 in FETCH while ack is pending (2-cycle latency) -> FLUSH; the old ack's data never appears on if_valid; next imem_addr=0x100.
- redir_valid in HOLD with if_ready=1 in the same cycle -> slot squashed, no transfer counted; next fetch at the redirect target; redirect coinciding with ack in FETCH -> data dropped, imem_addr=target.
- rst_n=0 during FETCH wait, stray imem_ack afterwards -> state IDLE, if_valid=0; pc restarts at RESET_PC on fetch_en. Separately, pc=0xFFFF_FFFC fetch -> next imem_addr=0x0.
